vx_dxa_issue_queue: RTL and testbench

VX_DXA_ISSUE_QUEUE -- requirements
Module: VX_dxa_issue_queue

---
 rtl/vx_dxa_issue_queue_pkg.sv | 27 ++
 rtl/vx_dxa_issue_queue_if.sv | 36 +++
 rtl/vx_dxa_issue_queue.sv | 119 +++++++++++
 tb/tb_vx_dxa_issue_queue.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_dxa_issue_queue_pkg.sv
// vx_dxa_issue_queue_pkg
//   Shared DXA constants and the issue-queue entry type.
//   No ports. Imported by the interface, the queue and the bench.
package vx_dxa_issue_queue_pkg;

  localparam int NC_WIDTH      = 2;
  localparam int NW_WIDTH      = 4;
  localparam int UUID_WIDTH    = 16;
  localparam int BAR_ADDR_W    = 4;

  // Widest argument payload an entry can hold.
  // A queue instance may carry a narrower ARG_DATAW.
  localparam int DXA_ARG_MAX_W = 64;

  localparam logic [2:0] DXA_OP_NOP   = 3'd0;
  localparam logic [2:0] DXA_OP_ISSUE = 3'd1;

  typedef struct packed {
    logic [2:0]               op;
    logic [NC_WIDTH-1:0]      core_id;
    logic [UUID_WIDTH-1:0]    uuid;
    logic [NW_WIDTH-1:0]      wid;
    logic [BAR_ADDR_W-1:0]    bar_addr;
    logic [DXA_ARG_MAX_W-1:0] args;
  } dxa_issue_q_entry_t;

endpackage

// File: rtl/vx_dxa_issue_queue_if.sv
// vx_dxa_issue_queue_if
//   Upstream DXA request channel into the issue queue.
//   Signals:
//     in_valid, in_ready   handshake
//     in_op, in_core_id, in_uuid, in_wid, in_bar_addr, in_args   request fields
//   Modports:
//     master  the request producer
//     slave   the issue queue
//
// Handshake: a transfer happens on a rising clk edge where in_valid && in_ready.
// The producer holds in_valid and all fields stable until that edge.
// in_ready does not depend on in_valid.
interface vx_dxa_issue_queue_if
  import vx_dxa_issue_queue_pkg::*;
#(
  parameter int ARG_DATAW = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_op;
  logic [NC_WIDTH-1:0]   in_core_id;
  logic [UUID_WIDTH-1:0] in_uuid;
  logic [NW_WIDTH-1:0]   in_wid;
  logic [BAR_ADDR_W-1:0] in_bar_addr;
  logic [ARG_DATAW-1:0]  in_args;

  modport master (
    output in_valid, in_op, in_core_id, in_uuid, in_wid, in_bar_addr, in_args,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_core_id, in_uuid, in_wid, in_bar_addr, in_args,
    output in_ready
  );
endinterface

// File: rtl/vx_dxa_issue_queue.sv
// vx_dxa_issue_queue
//   In-order issue queue between DXA request producers and the transfer controller.
//   The head entry is delivered as a one-cycle req_fire strobe; there is no downstream ready.
//   An ISSUE head waits until the controller is idle (xfer_active low) and has no completion
//   pending (done_rsp_valid low). Non-ISSUE heads leave immediately.
//   Ports:
//     clk, reset (async, active high)
//     in_if                      request channel (slave)
//     xfer_active                transfer controller busy
//     done_rsp_valid             completion response pending
//     req_fire                   head delivered this cycle
//     req_*, issue_bar_addr      head entry fields
//     occupancy                  entry count
//     perf_stall_cycles          saturating count of cycles with a blocked head
//   DEPTH must be a power of two and at least 2.
module vx_dxa_issue_queue
  import vx_dxa_issue_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ARG_DATAW = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_dxa_issue_queue_if.slave    in_if,
  input  logic                   xfer_active,
  input  logic                   done_rsp_valid,
  output logic                   req_fire,
  output logic [2:0]             req_op,
  output logic [NC_WIDTH-1:0]    req_core_id,
  output logic [UUID_WIDTH-1:0]  req_uuid,
  output logic [NW_WIDTH-1:0]    req_wid,
  output logic [BAR_ADDR_W-1:0]  issue_bar_addr,
  output logic [ARG_DATAW-1:0]   req_args,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0]            perf_stall_cycles
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  dxa_issue_q_entry_t mem [DEPTH];
  dxa_issue_q_entry_t head;
  dxa_issue_q_entry_t in_entry;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  logic             head_ok;
  logic             not_empty;

  assign not_empty      = (count != '0);
  // in_ready depends on count only, so a full queue refuses a push even in a popping cycle.
  assign in_if.in_ready = (count != FULL_CNT);
  assign push           = in_if.in_valid && in_if.in_ready;

  // Head is read from storage only, so a freshly pushed entry waits at least one cycle.
  assign head    = mem[rd_ptr];
  assign head_ok = not_empty &&
                   ((head.op != DXA_OP_ISSUE) || (!xfer_active && !done_rsp_valid));
  assign pop     = head_ok;

  assign req_fire       = head_ok;
  assign req_op         = head.op;
  assign req_core_id    = head.core_id;
  assign req_uuid       = head.uuid;
  assign req_wid        = head.wid;
  assign issue_bar_addr = head.bar_addr;
  assign req_args       = head.args[ARG_DATAW-1:0];
  assign occupancy      = count;

  always_comb begin
    in_entry          = '0;
    in_entry.op       = in_if.in_op;
    in_entry.core_id  = in_if.in_core_id;
    in_entry.uuid     = in_if.in_uuid;
    in_entry.wid      = in_if.in_wid;
    in_entry.bar_addr = in_if.in_bar_addr;
    in_entry.args     = DXA_ARG_MAX_W'(in_if.in_args);
  end

  // Storage has no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
    end else if (not_empty && !head_ok && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_vx_dxa_issue_queue.sv
module tb_vx_dxa_issue_queue;
  import vx_dxa_issue_queue_pkg::*;

  localparam int DEPTH     = 4;
  localparam int ARG_DATAW = 64;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  xfer_active;
  logic                  done_rsp_valid;
  logic                  req_fire;
  logic [2:0]            req_op;
  logic [NC_WIDTH-1:0]   req_core_id;
  logic [UUID_WIDTH-1:0] req_uuid;
  logic [NW_WIDTH-1:0]   req_wid;
  logic [BAR_ADDR_W-1:0] issue_bar_addr;
  logic [ARG_DATAW-1:0]  req_args;
  logic [2:0]            occupancy;
  logic [31:0]           perf_stall_cycles;

  vx_dxa_issue_queue_if #(.ARG_DATAW(ARG_DATAW)) in_if ();

  vx_dxa_issue_queue #(.DEPTH(DEPTH), .ARG_DATAW(ARG_DATAW)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_if             (in_if),
    .xfer_active       (xfer_active),
    .done_rsp_valid    (done_rsp_valid),
    .req_fire          (req_fire),
    .req_op            (req_op),
    .req_core_id       (req_core_id),
    .req_uuid          (req_uuid),
    .req_wid           (req_wid),
    .issue_bar_addr    (issue_bar_addr),
    .req_args          (req_args),
    .occupancy         (occupancy),
    .perf_stall_cycles (perf_stall_cycles)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [UUID_WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_if.in_valid    = 1'b0;
    in_if.in_op       = DXA_OP_NOP;
    in_if.in_core_id  = '0;
    in_if.in_uuid     = '0;
    in_if.in_wid      = '0;
    in_if.in_bar_addr = '0;
    in_if.in_args     = '0;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [NC_WIDTH-1:0] core,
                           input logic [UUID_WIDTH-1:0] uuid, input logic [NW_WIDTH-1:0] wid,
                           input logic [BAR_ADDR_W-1:0] bar, input logic [63:0] args);
    in_if.in_valid    = 1'b1;
    in_if.in_op       = op;
    in_if.in_core_id  = core;
    in_if.in_uuid     = uuid;
    in_if.in_wid      = wid;
    in_if.in_bar_addr = bar;
    in_if.in_args     = args;
  endtask

  // Reset pulse released away from the clock edge.
  task automatic do_reset();
    idle();
    xfer_active    = 1'b0;
    done_rsp_valid = 1'b0;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    tick();
  endtask

  // ---------------- stimulus tables ----------------
  logic [2:0] t35_op [6] = '{DXA_OP_ISSUE, DXA_OP_NOP, DXA_OP_ISSUE, 3'd2, DXA_OP_ISSUE, DXA_OP_NOP};

  initial begin
    int fires;
    int sent;
    int got;
    int cyc;
    logic model_ready;
    logic [UUID_WIDTH-1:0] exp_uuid;

    idle();
    xfer_active    = 1'b0;
    done_rsp_valid = 1'b0;
    reset          = 1'b1;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_if.in_ready, 1);
    check("rst_req_fire", req_fire, 0);
    check("rst_perf", perf_stall_cycles, 0);
    #2 reset = 1'b0;
    tick();

    // ---- single ISSUE, controller idle ----
    drive_req(DXA_OP_ISSUE, 2'd1, 16'h0031, 4'd3, 4'd2, 64'hDEAD_BEEF_0000_00A5);
    #1;
    check("t31_no_bypass", req_fire, 0);
    tick();
    idle();
    #1;
    check("t31_fire", req_fire, 1);
    check("t31_op", req_op, DXA_OP_ISSUE);
    check("t31_core", req_core_id, 1);
    check("t31_wid", req_wid, 3);
    check("t31_bar", issue_bar_addr, 2);
    check("t31_args", req_args, 64'hDEAD_BEEF_0000_00A5);
    check("t31_occ_1", occupancy, 1);
    tick();
    check("t31_occ_0", occupancy, 0);
    check("t31_fire_done", req_fire, 0);

    // ---- ISSUE heads blocked by busy controller ----
    do_reset();
    xfer_active = 1'b1;
    drive_req(DXA_OP_ISSUE, 2'd0, 16'h0A01, 4'd1, 4'd0, 64'h1);
    tick();                               // count 0 -> 1, no stall counted yet
    drive_req(DXA_OP_ISSUE, 2'd2, 16'h0A02, 4'd2, 4'd1, 64'h2);
    tick();                               // stall 1
    idle();
    fires = 0;
    for (int i = 0; i < 9; i++) begin     // stalls 2..10
      if (req_fire) fires++;
      tick();
    end
    if (req_fire) fires++;
    check("t32_no_fire", fires, 0);
    check("t32_perf_10", perf_stall_cycles, 10);
    check("t32_occ_2", occupancy, 2);
    xfer_active = 1'b0;
    #1;
    check("t32_first_fire", req_fire, 1);
    check("t32_first_uuid", req_uuid, 16'h0A01);
    tick();
    xfer_active = 1'b1;                   // controller picked up the first ISSUE
    #1;
    check("t32_busy_block", req_fire, 0);
    check("t32_head_uuid", req_uuid, 16'h0A02);
    tick();
    xfer_active    = 1'b0;
    done_rsp_valid = 1'b1;
    #1;
    check("t32_done_block", req_fire, 0);
    tick();
    done_rsp_valid = 1'b0;
    #1;
    check("t32_second_fire", req_fire, 1);
    check("t32_second_uuid", req_uuid, 16'h0A02);
    check("t32_perf_12", perf_stall_cycles, 12);
    tick();
    check("t32_occ_0", occupancy, 0);

    // ---- fill to DEPTH without pops ----
    do_reset();
    xfer_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_req(DXA_OP_ISSUE, 2'd0, 16'h0B00 + 16'(i), 4'd0, 4'd0, 64'(i));
      #1;
      check($sformatf("t33_ready_%0d", i), in_if.in_ready, (i < 4) ? 1'b1 : 1'b0);
      tick();
    end
    check("t33_occ_4", occupancy, 4);
    check("t33_ready_low", in_if.in_ready, 0);
    check("t33_head", req_uuid, 16'h0B00);

    // ---- full queue popping while in_valid ----
    do_reset();
    xfer_active = 1'b1;
    drive_req(DXA_OP_ISSUE, 2'd0, 16'h0C00, 4'd0, 4'd0, 64'h0);
    tick();
    for (int i = 1; i < 4; i++) begin
      drive_req(DXA_OP_NOP, 2'd0, 16'h0C00 + 16'(i), 4'd0, 4'd0, 64'h0);
      tick();
    end
    check("t34_full", occupancy, 4);
    xfer_active = 1'b0;
    drive_req(3'd2, 2'd3, 16'h0C04, 4'd5, 4'd6, 64'h44);
    #1;
    check("t34_ready_full", in_if.in_ready, 0);
    check("t34_fire_full", req_fire, 1);
    tick();
    check("t34_occ_3", occupancy, 3);
    check("t34_ready_next", in_if.in_ready, 1);
    check("t34_head_n1", req_uuid, 16'h0C01);
    tick();                               // push and pop together
    idle();
    check("t34_occ_still_3", occupancy, 3);
    for (int i = 2; i < 5; i++) begin
      #1;
      check($sformatf("t34_drain_fire_%0d", i), req_fire, 1);
      check($sformatf("t34_drain_uuid_%0d", i), req_uuid, 16'h0C00 + 16'(i));
      tick();
    end
    check("t34_empty", occupancy, 0);

    // ---- wrap-around ordering with random stalls (pointers start at 1) ----
    exp_q.delete();
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((got < 6) && (cyc < 300)) begin
      if ((sent < 6) && ($urandom_range(0, 2) != 0))
        drive_req(t35_op[sent], 2'(sent), 16'h0D00 + 16'(sent), 4'(sent), 4'(sent), 64'(sent));
      else
        idle();
      xfer_active    = ($urandom_range(0, 3) == 0);
      done_rsp_valid = ($urandom_range(0, 4) == 0);
      #1;
      model_ready = (exp_q.size() != DEPTH);
      check("t35_ready", in_if.in_ready, model_ready);
      if (req_fire) begin
        if (exp_q.size() == 0) begin
          check("t35_spurious_fire", req_fire, 0);
        end else begin
          exp_uuid = exp_q.pop_front();
          check("t35_order", req_uuid, exp_uuid);
          got++;
        end
      end
      if (in_if.in_valid && model_ready) begin
        exp_q.push_back(in_if.in_uuid);
        sent++;
      end
      tick();
      cyc++;
    end
    check("t35_all_out", got, 6);
    check("t35_q_empty", exp_q.size(), 0);
    idle();
    xfer_active    = 1'b0;
    done_rsp_valid = 1'b0;

    // ---- reset mid-operation ----
    do_reset();
    xfer_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(DXA_OP_ISSUE, 2'd0, 16'h0E00 + 16'(i), 4'd0, 4'd0, 64'h0);
      tick();
    end
    idle();
    check("t36_occ_3", occupancy, 3);
    #2;
    reset       = 1'b1;
    xfer_active = 1'b0;
    #1;
    check("t36_rst_occ", occupancy, 0);
    check("t36_rst_fire", req_fire, 0);
    check("t36_rst_ready", in_if.in_ready, 1);
    check("t36_rst_perf", perf_stall_cycles, 0);
    tick();
    check("t36_rst_fire_held", req_fire, 0);
    #2 reset = 1'b0;
    fires = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (req_fire) fires++;
      if (occupancy != 0) fires++;
    end
    check("t36_post_quiet", fires, 0);
    drive_req(DXA_OP_NOP, 2'd1, 16'h0E10, 4'd1, 4'd1, 64'h9);
    tick();
    idle();
    #1;
    check("t36_new_fire", req_fire, 1);
    check("t36_new_uuid", req_uuid, 16'h0E10);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
